// File: rtl/addsub_pkg.sv
// addsub_pkg -- shared definitions for the add/subtract controller.
//   state_t                 : controller FSM states (LOAD_A, LOAD_B, COMPUTE, SHOW)
//   SEG_0..SEG_8            : active-low seven-segment patterns, bit order g..a
//   SEG_DASH / SEG_BLANK    : minus sign and blank digit patterns
//   DEBOUNCE_CYCLES_DEFAULT : default stable-cycle count for the button debouncer
//   state_onehot()          : LEDR encoding of a state
//   seg_digit()             : magnitude (0..8) to segment pattern
package addsub_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef enum logic [1:0] {
    ST_LOAD_A  = 2'd0,
    ST_LOAD_B  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // State encoding doubles as the bit index of the one-hot LED.
  function automatic logic [3:0] state_onehot(input state_t s);
    return 4'b0001 << s;
  endfunction

  // Magnitudes above 8 never occur for a 4-bit signed value; they blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] mag);
    logic [6:0] seg;
    case (mag)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/addsub_if.sv
// addsub_if -- board-side signal bundle of the add/subtract controller.
//   sw      : 4-bit two's complement operand switches
//   op      : operation select (0 = add, 1 = subtract)
//   enter_n : raw active-low pushbutton
//   hex0    : magnitude digit (active-low segments)
//   hex1    : sign digit (active-low segments)
//   ledr    : one-hot state indicator
//   ovf     : signed overflow flag
// master drives the user inputs (board / bench), slave is the controller view.
interface addsub_if;
  logic [3:0] sw;
  logic       op;
  logic       enter_n;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [3:0] ledr;
  logic       ovf;

  modport master (
    output sw, op, enter_n,
    input  hex0, hex1, ledr, ovf
  );

  modport slave (
    input  sw, op, enter_n,
    output hex0, hex1, ledr, ovf
  );
endinterface

// File: rtl/addsub_signed_seg_decoder.sv
// signed_seg_decoder -- combinational 4-bit signed value to two-digit display.
//   value : 4-bit two's complement value (-8..7)
//   seg   : {HEX1, HEX0}; HEX1 is '-' for negative values else blank,
//           HEX0 shows the magnitude (0..8), all active-low, bit order g..a
module signed_seg_decoder
  import addsub_pkg::*;
(
  input  logic [3:0]  value,
  output logic [13:0] seg
);

  logic [3:0] mag;

  // Four-bit negation of -8 wraps to 4'b1000, which is exactly magnitude 8.
  always_comb begin
    mag = value[3] ? (4'd0 - value) : value;
    seg = {(value[3] ? SEG_DASH : SEG_BLANK), seg_digit(mag)};
  end

endmodule

// File: rtl/addsub_controller.sv
// addsub_controller -- two-operand 4-bit signed adder/subtractor driven by a
// single debounced pushbutton.
//   CLOCK_50 : sole clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   SW       : operand entry, 4-bit two's complement
//   OP       : 0 = A+B, 1 = A-B, captured together with B
//   ENTER_N  : raw active-low pushbutton (asynchronous, bouncy)
//   HEX0     : magnitude digit, active-low segments g..a
//   HEX1     : sign digit, active-low segments g..a
//   LEDR     : one-hot state {SHOW, COMPUTE, LOAD_B, LOAD_A}
//   OVF      : signed overflow of the last computed result
module addsub_controller
  import addsub_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
(
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] SW,
  input  logic       OP,
  input  logic       ENTER_N,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [3:0] LEDR,
  output logic       OVF
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button conditioning
  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             press_reg;
  logic             accept;

  // Controller state and datapath
  state_t      state_reg, state_next;
  logic [3:0]  a_reg, a_next;
  logic [3:0]  b_reg, b_next;
  logic        op_reg, op_next;
  logic [3:0]  result_reg, result_next;
  logic        ovf_reg, ovf_next;
  logic signed [4:0] ext_a, ext_b, calc;

  // Display path
  logic [3:0]  disp_value;
  logic        disp_dash;
  logic [13:0] disp_seg;
  logic [6:0]  hex0_reg, hex0_next;
  logic [6:0]  hex1_reg, hex1_next;
  logic [3:0]  led_reg, led_next;

  // ---------------------------------------------------------------------------
  // Synchronizer and debouncer. The counter runs while the synchronized input
  // differs from the accepted level; it reaching CNT_LAST means the new level
  // has been held for DEBOUNCE_CYCLES consecutive cycles. Any return to the
  // accepted level restarts the count, so short glitches never get through.
  // ---------------------------------------------------------------------------
  assign accept = (sync2_reg != level_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync1_reg <= ENTER_N;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (accept) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      // Only the accepted high-to-low edge produces a pulse.
      press_reg <= accept && !sync2_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ST_LOAD_A;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic. COMPUTE always lasts one cycle, so a press pulse
  // landing there is simply not looked at.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD_A:  if (press_reg) state_next = ST_LOAD_B;
      ST_LOAD_B:  if (press_reg) state_next = ST_COMPUTE;
      ST_COMPUTE: state_next = ST_SHOW;
      ST_SHOW:    if (press_reg) state_next = ST_LOAD_A;
      default:    state_next = ST_LOAD_A;
    endcase
  end

  // Five-bit sign-extended arithmetic; bits 4 and 3 disagree exactly when the
  // result does not fit in 4-bit two's complement.
  assign ext_a = $signed({a_reg[3], a_reg});
  assign ext_b = $signed({b_reg[3], b_reg});
  assign calc  = op_reg ? (ext_a - ext_b) : (ext_a + ext_b);

  // FSM: output / datapath next values
  always_comb begin
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    case (state_reg)
      ST_LOAD_A: begin
        if (press_reg) a_next = SW;
      end
      ST_LOAD_B: begin
        if (press_reg) begin
          b_next  = SW;
          op_next = OP;
        end
      end
      ST_COMPUTE: begin
        result_next = calc[3:0];
        ovf_next    = calc[4] ^ calc[3];
      end
      ST_SHOW: begin
        if (press_reg) ovf_next = 1'b0;
      end
      default: ;
    endcase
  end

  // Display source follows the state being entered so the registered outputs
  // line up with LEDR: live switches while loading, the result while showing.
  always_comb begin
    disp_value = SW;
    disp_dash  = 1'b0;
    if (state_next == ST_SHOW) begin
      disp_value = result_next;
      disp_dash  = ovf_next;
    end
  end

  signed_seg_decoder u_seg_decoder (
    .value (disp_value),
    .seg   (disp_seg)
  );

  always_comb begin
    led_next  = state_onehot(state_next);
    hex1_next = disp_dash ? SEG_DASH : disp_seg[13:7];
    hex0_next = disp_dash ? SEG_DASH : disp_seg[6:0];
  end

  // Datapath and output registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      a_reg      <= 4'd0;
      b_reg      <= 4'd0;
      op_reg     <= 1'b0;
      result_reg <= 4'd0;
      ovf_reg    <= 1'b0;
      hex0_reg   <= SEG_0;
      hex1_reg   <= SEG_BLANK;
      led_reg    <= 4'b0001;
    end else begin
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      hex0_reg   <= hex0_next;
      hex1_reg   <= hex1_next;
      led_reg    <= led_next;
    end
  end

  assign HEX0 = hex0_reg;
  assign HEX1 = hex1_reg;
  assign LEDR = led_reg;
  assign OVF  = ovf_reg;

endmodule

// File: tb/tb_addsub_controller.sv
module tb_addsub_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_if bus ();

  addsub_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .SW       (bus.sw),
    .OP       (bus.op),
    .ENTER_N  (bus.enter_n),
    .HEX0     (bus.hex0),
    .HEX1     (bus.hex1),
    .LEDR     (bus.ledr),
    .OVF      (bus.ovf)
  );

  typedef struct packed {
    logic [6:0] hex1;
    logic [6:0] hex0;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  function automatic logic [6:0] digit(input int m);
    case (m)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int to_int(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic logic [13:0] disp_of(input int v);
    if (v < 0) return {DASH, digit(-v)};
    return {BLANK, digit(v)};
  endfunction

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic op);
    exp_t e;
    int r;
    r = op ? to_int(a) - to_int(b) : to_int(a) + to_int(b);
    e.ovf = (r < -8) || (r > 7);
    if (e.ovf) {e.hex1, e.hex0} = {DASH, DASH};
    else       {e.hex1, e.hex0} = disp_of(r);
    return e;
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int low_cycles);
    bus.enter_n = 1'b0;
    tick(low_cycles);
    bus.enter_n = 1'b1;
    tick(12);
  endtask

  task automatic wait_led(input logic [3:0] want, input string tag);
    for (int i = 0; i < 60; i++) begin
      if (bus.ledr === want) break;
      @(negedge clk);
    end
    check(tag, {10'd0, bus.ledr}, {10'd0, want});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_led"}, {10'd0, bus.ledr}, 14'b0001);
    check({tag, "_ovf"}, {13'd0, bus.ovf}, 14'd0);
    check({tag, "_hex"}, {bus.hex1, bus.hex0}, {BLANK, 7'b1000000});
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic op);
    exp_t e;
    wait_led(4'b0001, "idle_load_a");
    bus.sw = a;
    tick(2);
    check("live_sw_a", {bus.hex1, bus.hex0}, disp_of(to_int(a)));
    press(20);
    check("to_load_b", {10'd0, bus.ledr}, 14'b0010);
    bus.sw = b;
    bus.op = op;
    tick(2);
    check("live_sw_b", {bus.hex1, bus.hex0}, disp_of(to_int(b)));
    sb_q.push_back(model(a, b, op));
    press(20);
    wait_led(4'b1000, "to_show");
    bus.sw = ~b;   // result display must not follow the switches now
    tick(2);
    e = sb_q.pop_front();
    check("show_hex", {bus.hex1, bus.hex0}, {e.hex1, e.hex0});
    check("show_ovf", {13'd0, bus.ovf}, {13'd0, e.ovf});
    $display("op a=%b b=%b op=%0d -> hex1=%b hex0=%b ovf=%0d", a, b, op, bus.hex1, bus.hex0, bus.ovf);
    press(20);
    check("back_load_a", {10'd0, bus.ledr}, 14'b0001);
    check("ovf_cleared", {13'd0, bus.ovf}, 14'd0);
  endtask

  logic [3:0] ta[8];
  logic [3:0] tbv[8];
  logic       top[8];

  initial begin
    ta  = '{4'b0011, 4'b0111, 4'b1101, 4'b1000, 4'b0010, 4'b0000, 4'b1000, 4'b1111};
    tbv = '{4'b0010, 4'b0001, 4'b0101, 4'b0001, 4'b0101, 4'b0000, 4'b1000, 4'b1111};
    top = '{1'b0,    1'b0,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0,    1'b1};

    bus.sw = 4'd0;
    bus.op = 1'b0;
    bus.enter_n = 1'b1;
    tick(3);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    tick(3);
    check("after_reset_led", {10'd0, bus.ledr}, 14'b0001);

    // Two-cycle glitch must be ignored.
    bus.enter_n = 1'b0;
    tick(2);
    bus.enter_n = 1'b1;
    tick(20);
    check("glitch_ignored", {10'd0, bus.ledr}, 14'b0001);

    // Long hold gives exactly one advance.
    press(100);
    check("hold_one_advance", {10'd0, bus.ledr}, 14'b0010);
    press(20);
    wait_led(4'b1000, "hold_to_show");
    press(20);
    check("hold_back_a", {10'd0, bus.ledr}, 14'b0001);

    for (int i = 0; i < 8; i++) run_op(ta[i], tbv[i], top[i]);

    // Reset while showing an overflowed result.
    bus.sw = 4'b0111;
    press(20);
    bus.sw = 4'b0001;
    bus.op = 1'b0;
    press(20);
    wait_led(4'b1000, "rst_show_reach");
    check("rst_show_ovf_set", {13'd0, bus.ovf}, 14'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_in_show");
    bus.sw = 4'd0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    $display("reset in SHOW: led=%b ovf=%0d", bus.ledr, bus.ovf);

    // Reset during the single COMPUTE cycle.
    bus.sw = 4'b0011;
    press(20);
    bus.sw = 4'b0010;
    bus.op = 1'b0;
    sb_q.push_back(model(4'b0011, 4'b0010, 1'b0));
    bus.enter_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ledr === 4'b0100) break;
      @(negedge clk);
    end
    check("reach_compute", {10'd0, bus.ledr}, 14'b0100);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_in_compute");
    sb_q.delete();   // abandoned operation produces no result
    bus.enter_n = 1'b1;
    bus.sw = 4'd0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("post_compute_rst_idle", {10'd0, bus.ledr}, 14'b0001);
    check("post_compute_rst_hex", {bus.hex1, bus.hex0}, {BLANK, 7'b1000000});
    $display("reset in COMPUTE: led=%b ovf=%0d", bus.ledr, bus.ovf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
